// File: rtl/weighted_voter_pkg.sv
// Shared types and defaults for the weighted ballot voter.
package voter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_NP_W    = 32;
  localparam int unsigned DEF_VIP_W   = 8;
  localparam int unsigned DEF_VVIP_W  = 1;
  localparam int unsigned DEF_NP_WT   = 1;
  localparam int unsigned DEF_VIP_WT  = 4;
  localparam int unsigned DEF_VVIP_WT = 16;
  localparam int unsigned DEF_RES_W   = 8;

  // Width able to hold the largest possible unsaturated weighted sum.
  function automatic int unsigned sum_width(
    input int unsigned np_w,
    input int unsigned np_wt,
    input int unsigned vip_w,
    input int unsigned vip_wt,
    input int unsigned vvip_w,
    input int unsigned vvip_wt
  );
    return $clog2(np_w * np_wt + vip_w * vip_wt + vvip_w * vvip_wt + 1);
  endfunction

endpackage

// File: rtl/weighted_voter_if.sv
// Session control, ballot inputs and tally outputs of the weighted voter.
interface weighted_voter_if #(
  parameter int unsigned NP_W   = 32,
  parameter int unsigned VIP_W  = 8,
  parameter int unsigned VVIP_W = 1,
  parameter int unsigned RES_W  = 8
);
  logic              start;
  logic              close;
  logic [NP_W-1:0]   np;
  logic [VIP_W-1:0]  vip;
  logic [VVIP_W-1:0] vvip;
  logic [RES_W-1:0]  threshold;
  logic [RES_W-1:0]  result;
  logic              pass;
  logic              session_open;
  logic              done;

  modport master (
    output start, close, np, vip, vvip, threshold,
    input  result, pass, session_open, done
  );

  modport slave (
    input  start, close, np, vip, vvip, threshold,
    output result, pass, session_open, done
  );
endinterface

// File: rtl/weighted_voter_popcount.sv
// Combinational popcount of a ballot vector scaled by a per-class weight.
module weighted_popcount #(
  parameter int unsigned W     = 8,
  parameter int unsigned WT    = 1,
  parameter int unsigned OUT_W = 8
) (
  input  logic [W-1:0]     x,
  output logic [OUT_W-1:0] y
);
  logic [OUT_W-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < W; i++) begin
      cnt = cnt + OUT_W'(x[i]);
    end
  end

  assign y = cnt * OUT_W'(WT);
endmodule

// File: rtl/weighted_voter.sv
// Weighted voter: session FSM, sticky ballots, saturating tally and threshold check.
module weighted_voter
  import voter_pkg::*;
#(
  parameter int unsigned NP_W    = DEF_NP_W,
  parameter int unsigned VIP_W   = DEF_VIP_W,
  parameter int unsigned VVIP_W  = DEF_VVIP_W,
  parameter int unsigned NP_WT   = DEF_NP_WT,
  parameter int unsigned VIP_WT  = DEF_VIP_WT,
  parameter int unsigned VVIP_WT = DEF_VVIP_WT,
  parameter int unsigned RES_W   = DEF_RES_W
) (
  input  logic             clk,
  input  logic             reset,
  weighted_voter_if.slave  bus
);
  localparam int unsigned SUM_W = sum_width(NP_W, NP_WT, VIP_W, VIP_WT, VVIP_W, VVIP_WT);
  localparam int unsigned CMP_W = (SUM_W > RES_W) ? SUM_W : RES_W;
  localparam logic [CMP_W-1:0] RES_MAX = CMP_W'((64'd1 << RES_W) - 64'd1);

  state_e            state_q, state_d;
  logic [NP_W-1:0]   np_b_q, np_b_d;
  logic [VIP_W-1:0]  vip_b_q, vip_b_d;
  logic [VVIP_W-1:0] vvip_b_q, vvip_b_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;
  logic              session_open_q, session_open_d;

  logic [NP_W-1:0]   np_upd;
  logic [VIP_W-1:0]  vip_upd;
  logic [VVIP_W-1:0] vvip_upd;
  logic [SUM_W-1:0]  np_part, vip_part, vvip_part, sum;
  logic [CMP_W-1:0]  sum_ext;
  logic [RES_W-1:0]  sat_res;

  // Tally is taken over the post-update ballots so this cycle's votes land on this edge.
  assign np_upd   = np_b_q | bus.np;
  assign vip_upd  = vip_b_q | bus.vip;
  assign vvip_upd = vvip_b_q | bus.vvip;

  weighted_popcount #(.W(NP_W), .WT(NP_WT), .OUT_W(SUM_W)) u_pc_np (
    .x (np_upd),
    .y (np_part)
  );

  weighted_popcount #(.W(VIP_W), .WT(VIP_WT), .OUT_W(SUM_W)) u_pc_vip (
    .x (vip_upd),
    .y (vip_part)
  );

  weighted_popcount #(.W(VVIP_W), .WT(VVIP_WT), .OUT_W(SUM_W)) u_pc_vvip (
    .x (vvip_upd),
    .y (vvip_part)
  );

  assign sum     = np_part + vip_part + vvip_part;
  assign sum_ext = CMP_W'(sum);
  assign sat_res = (sum_ext > RES_MAX) ? '1 : sum_ext[RES_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = OPEN;
      OPEN:    if (bus.close) state_d = DONE;
      DONE:    if (bus.start) state_d = OPEN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    np_b_d         = np_b_q;
    vip_b_d        = vip_b_q;
    vvip_b_d       = vvip_b_q;
    result_d       = result_q;
    pass_d         = pass_q;
    done_d         = 1'b0;
    session_open_d = (state_d == OPEN);
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          np_b_d   = '0;
          vip_b_d  = '0;
          vvip_b_d = '0;
          result_d = '0;
          pass_d   = 1'b0;
        end
      end
      OPEN: begin
        np_b_d   = np_upd;
        vip_b_d  = vip_upd;
        vvip_b_d = vvip_upd;
        result_d = sat_res;
        if (bus.close) begin
          pass_d = (sat_res >= bus.threshold);
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      np_b_q         <= '0;
      vip_b_q        <= '0;
      vvip_b_q       <= '0;
      result_q       <= '0;
      pass_q         <= 1'b0;
      done_q         <= 1'b0;
      session_open_q <= 1'b0;
    end else begin
      np_b_q         <= np_b_d;
      vip_b_q        <= vip_b_d;
      vvip_b_q       <= vvip_b_d;
      result_q       <= result_d;
      pass_q         <= pass_d;
      done_q         <= done_d;
      session_open_q <= session_open_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.pass         = pass_q;
  assign bus.done         = done_q;
  assign bus.session_open = session_open_q;
endmodule

// File: doc/weighted_voter.md
# weighted_voter

Parametrised weighted-ballot voting block with an explicit session state machine. Three voter classes (normal, VIP, VVIP) of configurable width and weight cast sticky votes while a session is open. A registered, saturating tally is kept throughout the session. On close, the tally is frozen and compared against a threshold, and a one-cycle done pulse is raised. It sits in the P1 practice datapath as the generalised successor to the fixed 32/8/1 voter.

## Interface
- NP_W, 32, number of normal voters (weight NP_WT)
- VIP_W, 8, number of VIP voters (weight VIP_WT)
- VVIP_W, 1, number of VVIP voters (weight VVIP_WT)
- NP_WT, 1, weight of one normal vote
- VIP_WT, 4, weight of one VIP vote
- VVIP_WT, 16, weight of one VVIP vote
- RES_W, 8, tally/threshold width
- Ports:
  - clk  in  1  single clock, all state on rising edge
  - reset  in  1  synchronous, active-high; clears all state
  - start  in  1  open a new session (clears ballots)
  - close  in  1  end current session
  - np  in  NP_W  normal votes, bit i = voter i votes
  - vip  in  VIP_W  VIP votes
  - vvip  in  VVIP_W  VVIP votes
  - threshold  in  RES_W  pass threshold, sampled at close
  - result  out  RES_W  registered weighted tally
  - pass  out  1  result >= threshold, valid from done onward
  - session_open  out  1  high in OPEN
  - done  out  1  one-cycle pulse on entering DONE

## Operation
- States: IDLE, OPEN, DONE. Reset state is IDLE.
- Reset values: result=0, pass=0, session_open=0, done=0, ballots=0.
- IDLE --start--> OPEN. In IDLE, close and votes are ignored.
- OPEN:
  - Each cycle, the ballot registers take ballot | input for every class. A vote is sticky and cannot be withdrawn.
  - result <= sat(popcnt(np_b')*NP_WT + popcnt(vip_b')*VIP_WT + popcnt(vvip_b')*VVIP_WT). Here x_b' is the post-update ballot value, so votes presented in a cycle are included in that edge's result.
- OPEN --close--> DONE. Votes presented in the close cycle are counted. On the same edge, pass <= (new result >= threshold) and done <= 1.
- DONE: result and pass are held, votes are ignored, and done is high for exactly one cycle.
- DONE --start--> OPEN: ballots, result and pass are cleared to 0, and voting restarts on the next cycle.
- Simultaneous events:
  - start+close in IDLE/DONE: start wins.
  - start+close in OPEN: close wins and start is ignored.
  - start in OPEN alone: ignored, with no clear.
  - reset: overrides everything in any state, mid-session included, and returns to IDLE with all outputs 0.
- Arithmetic:
  - The internal sum is computed at full width: clog2(NP_W*NP_WT + VIP_W*VIP_WT + VVIP_W*VVIP_WT + 1).
  - The sum saturates at 2^RES_W-1 and never wraps.
  - The threshold compare is unsigned.

## Timing
- Vote-to-result latency is 1 cycle: a vote at edge k is visible on result after edge k.
- close at edge k gives result/pass final and done=1 after edge k, with done=0 after edge k+1.
- session_open is registered and rises the cycle after start is accepted.
- No combinational path from any input to any output.

## Structure
- Package voter_pkg holds:
  - state enum {IDLE, OPEN, DONE}
  - default width/weight constants
  - a function computing full sum width
- Sub-module weighted_popcount (combinational, parameters W and WT): returns popcount(x)*WT at full width. It is instantiated once per class.
- Top level holds the FSM, ballot registers, adder and saturation logic, and the result/pass/done registers.

## Test plan
- Defaults: reset, start, np=32'h0000_000F, vip=8'h03, vvip=0 for 1 cycle.
  - Required: result=12 next cycle; a later np=0 keeps result=12 (sticky).
- Defaults: in OPEN, all ones (np=32'hFFFF_FFFF, vip=8'hFF, vvip=1) → result=80. Then with RES_W=6 the same stimulus → result=63 (saturation).
- threshold=20, votes giving 16 then close with vip=8'h01 in the close cycle → result=20, pass=1, done high exactly 1 cycle. Repeat with threshold=21 → pass=0.
- Votes and close in IDLE → result stays 0, no done. start+close together in OPEN → DONE, not restarted.
- DONE with result=20, then start → result=0, pass=0, session_open=1. Reset asserted mid-OPEN → all outputs 0, state IDLE, next votes ignored until start.
